// File: rtl/event_fetcher.sv
// ----------------------------------------------------------------------------
// event_fetcher
//
// Host-side counterpart of event_reader, in the f125_clk domain. It issues
// LO / HI / POP commands to read one 64-bit FIFO word as two 32-bit halves.
// It reassembles each word as {hi, lo} and streams one event of
// WORDS_PER_EVENT words downstream under a valid/ready handshake. It also
// counts completed events and aborts an event if the FIFO stays empty for
// TIMEOUT cycles.
//
// Handshake: word_o / word_idx_o are stable for as long as word_valid_o is
// high. A word is transferred on the rising edge where word_valid_o and
// word_ready_i are both high. word_valid_o never depends combinationally on
// word_ready_i.
//
// Ports:
//   clk            in   system clock (f125_clk)
//   areset         in   asynchronous active-high reset
//   start_i        in   request one event fetch (sampled in IDLE only)
//   fifo_empty_i   in   event FIFO empty flag
//   event_half_i   in   32-bit response half from event_reader
//   cmd_o          out  registered command to event_reader
//   word_o         out  reassembled word {hi, lo}
//   word_valid_o   out  word_o valid
//   word_ready_i   in   downstream accepts word_o
//   word_idx_o     out  index of word_o within the event
//   event_done_o   out  1-cycle pulse on acceptance of the last word
//   error_o        out  1-cycle pulse on timeout abort
//   busy_o         out  high in every state except IDLE
//   event_count_o  out  completed events (wraps)
//   dbg_state_o    out  current FSM state, for observation only
// ----------------------------------------------------------------------------
module event_fetcher #(
  parameter int          WORDS_PER_EVENT = 16,
  parameter int          RESP_LAT        = 2,
  parameter int          TIMEOUT         = 1023,
  parameter logic [7:0]  CMD_IDLE        = 8'h00,
  parameter logic [7:0]  CMD_LO          = 8'h01,
  parameter logic [7:0]  CMD_HI          = 8'h02,
  parameter logic [7:0]  CMD_POP         = 8'h03
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        start_i,
  input  logic        fifo_empty_i,
  input  logic [31:0] event_half_i,
  output logic [7:0]  cmd_o,
  output logic [63:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [3:0]  word_idx_o,
  output logic        event_done_o,
  output logic        error_o,
  output logic        busy_o,
  output logic [15:0] event_count_o,
  output logic [2:0]  dbg_state_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_REQ_LO  = 3'd2;
  localparam logic [2:0] S_REQ_HI  = 3'd3;
  localparam logic [2:0] S_POP     = 3'd4;
  localparam logic [2:0] S_PRESENT = 3'd5;

  localparam int LAT_W = $clog2(RESP_LAT + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(RESP_LAT - 1);
  localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(TIMEOUT - 1);
  localparam logic [3:0]       LAST_IDX = 4'(WORDS_PER_EVENT - 1);

  logic [2:0]       state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [3:0]       idx_q, idx_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [63:0]      word_q, word_d;
  logic             valid_q, valid_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [15:0]      count_q, count_d;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    to_d    = to_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    word_d  = word_q;
    valid_d = valid_q;
    count_d = count_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CHECK;
          idx_d   = 4'd0;
          to_d    = '0;
        end
      end
      S_CHECK: begin
        if (!fifo_empty_i) begin
          state_d = S_REQ_LO;
          to_d    = '0;
          lat_d   = '0;
        end else if (to_q == LAST_TO) begin
          // The cycle holding LAST_TO is the TIMEOUT-th empty cycle, so the
          // error pulse lands exactly TIMEOUT cycles after the first one.
          state_d = S_IDLE;
          err_d   = 1'b1;
          to_d    = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_REQ_LO: begin
        if (lat_q == LAST_LAT) begin
          lo_d    = event_half_i;
          lat_d   = '0;
          state_d = S_REQ_HI;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_REQ_HI: begin
        if (lat_q == LAST_LAT) begin
          hi_d    = event_half_i;
          lat_d   = '0;
          state_d = S_POP;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_POP: begin
        // The word is popped before it is offered, so backpressure can
        // never leave the FIFO head half-consumed.
        word_d  = {hi_q, lo_q};
        valid_d = 1'b1;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (word_ready_i) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            count_d = count_q + 1'b1;
            idx_d   = 4'd0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_CHECK;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // cmd_o and busy_o are registered from the next state, so they line up
    // with the state the FSM is in on the following cycle.
    case (state_d)
      S_REQ_LO: cmd_d = CMD_LO;
      S_REQ_HI: cmd_d = CMD_HI;
      S_POP:    cmd_d = CMD_POP;
      default:  cmd_d = CMD_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      to_q    <= '0;
      idx_q   <= 4'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      word_q  <= 64'd0;
      valid_q <= 1'b0;
      cmd_q   <= CMD_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      to_q    <= to_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign cmd_o         = cmd_q;
  assign word_o        = word_q;
  assign word_valid_o  = valid_q;
  assign word_idx_o    = idx_q;
  assign event_done_o  = done_q;
  assign error_o       = err_q;
  assign busy_o        = busy_q;
  assign event_count_o = count_q;
  assign dbg_state_o   = state_q;

endmodule
